// File: rtl/cpu_debug_monitor_if.sv
// Board-side signal bundle for the CPU debug monitor: raw button/switches,
// probe inputs and the step/LED outputs. clk and rst stay outside.
interface cpu_debug_monitor_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int LED_W  = 8
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BYTE_W = ((DATA_W / LED_W) > 1) ? $clog2(DATA_W / LED_W) : 1;

  logic                     Step_BTN;
  logic                     run_sw;
  logic                     hold_sw;
  logic [CH_W+BYTE_W-1:0]   sel;
  logic [NUM_CH*DATA_W-1:0] probe_bus;
  logic                     cpu_clk_en;
  logic [LED_W-1:0]         LED;
  logic [15:0]              step_count;

  // Board / top-level side: drives the raw controls and the probes.
  modport master (
    output Step_BTN, run_sw, hold_sw, sel, probe_bus,
    input  cpu_clk_en, LED, step_count
  );

  // Monitor side.
  modport slave (
    input  Step_BTN, run_sw, hold_sw, sel, probe_bus,
    output cpu_clk_en, LED, step_count
  );
endinterface

// File: rtl/cpu_debug_monitor.sv
// Debug front end for the single-cycle CPU: debounced single-step or
// free-running step pulses, post-step probe snapshot and an LED slice mux.
module cpu_debug_monitor #(
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 4,
  parameter int LED_W      = 8,
  parameter int DEB_CYCLES = 1000000,
  parameter int RUN_DIV    = 50000000
) (
  input  logic               clk_100MHz,
  input  logic               rst,
  cpu_debug_monitor_if.slave mon
);
  localparam int NSLICE = DATA_W / LED_W;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BYTE_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int CNT_W  = $clog2(DEB_CYCLES);
  localparam int DIV_W  = $clog2(RUN_DIV);

  // Slice select: zero for an out-of-range channel or slice index.
  function automatic logic [LED_W-1:0] pick_slice(
    input logic [NUM_CH*DATA_W-1:0] src,
    input logic [CH_W-1:0]          ch,
    input logic [BYTE_W-1:0]        sl
  );
    logic [LED_W-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < NSLICE; s++) begin
        if (int'(ch) == c && int'(sl) == s) begin
          r = src[c*DATA_W + s*LED_W +: LED_W];
        end
      end
    end
    return r;
  endfunction

  logic                     btn_p0, btn_p1;
  logic                     run_p0, run_p1, run_p2;
  logic                     hold_p0, hold_p1;
  logic [1:0]               sync_fill;
  logic                     btn_block;
  logic [CNT_W-1:0]         deb_cnt;
  logic                     stable;
  logic [DIV_W-1:0]         div_cnt;
  logic                     cpu_clk_en_q;
  logic                     step_vld_p1;
  logic [15:0]              step_cnt;
  logic [NUM_CH*DATA_W-1:0] snap;
  logic [LED_W-1:0]         led_q;
  logic [LED_W-1:0]         led_nxt;

  logic deb_accept;
  logic step_rise;
  logic mode_chg;

  assign deb_accept = (btn_p1 != stable) && (deb_cnt == CNT_W'(DEB_CYCLES - 1));
  // A 0->1 acceptance is a step request unless the button was held through reset.
  assign step_rise  = deb_accept && btn_p1 && !btn_block;
  assign mode_chg   = (run_p1 != run_p2);

  assign mon.cpu_clk_en = cpu_clk_en_q;
  assign mon.LED        = led_q;
  assign mon.step_count = step_cnt;

  // Two-flop synchronisers for the raw button and switches.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      btn_p0  <= 1'b0;
      btn_p1  <= 1'b0;
      run_p0  <= 1'b0;
      run_p1  <= 1'b0;
      hold_p0 <= 1'b0;
      hold_p1 <= 1'b0;
    end else begin
      btn_p0  <= mon.Step_BTN;
      btn_p1  <= btn_p0;
      run_p0  <= mon.run_sw;
      run_p1  <= run_p0;
      hold_p0 <= mon.hold_sw;
      hold_p1 <= hold_p0;
    end
  end

  // Debouncer plus the held-through-reset lockout. The lockout flag only
  // gates the step request and is released once the synchroniser has refilled
  // with real samples showing the button up, so a marginal capture of the raw
  // level during reset just delays or skips one lockout.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      deb_cnt   <= '0;
      stable    <= 1'b0;
      sync_fill <= 2'b00;
      btn_block <= mon.Step_BTN;
    end else begin
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && !btn_p1 && !stable) begin
        btn_block <= 1'b0;
      end
      if (btn_p1 != stable) begin
        if (deb_accept) begin
          stable  <= btn_p1;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Step pulse generation: debounced press in STEP mode, divider in RUN mode.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      run_p2       <= 1'b0;
      div_cnt      <= '0;
      cpu_clk_en_q <= 1'b0;
    end else begin
      run_p2 <= run_p1;
      if (mode_chg) begin
        div_cnt      <= '0;
        cpu_clk_en_q <= 1'b0;
      end else if (run_p1) begin
        cpu_clk_en_q <= (div_cnt == DIV_W'(RUN_DIV - 2));
        div_cnt      <= (div_cnt == DIV_W'(RUN_DIV - 1)) ? '0 : div_cnt + 1'b1;
      end else begin
        div_cnt      <= '0;
        cpu_clk_en_q <= step_rise;
      end
    end
  end

  // Step counter and post-step snapshot (one edge after the step edge).
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      step_vld_p1 <= 1'b0;
      step_cnt    <= '0;
      snap        <= '0;
    end else begin
      step_vld_p1 <= cpu_clk_en_q;
      step_cnt    <= step_cnt + {15'd0, cpu_clk_en_q};
      if (step_vld_p1) begin
        snap <= mon.probe_bus;
      end
    end
  end

  // Combinational LED slice from snapshot or live probes.
  always_comb begin
    led_nxt = pick_slice(hold_p1 ? snap : mon.probe_bus,
                         mon.sel[CH_W+BYTE_W-1 -: CH_W],
                         mon.sel[BYTE_W-1:0]);
  end

  // Registered LED output.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_nxt;
    end
  end
endmodule

// File: doc/cpu_debug_monitor.md
Name: cpu_debug_monitor

Overview:
- Parametrised board-level debug front end for the single-cycle CPU experiments.
- Debounces the step button and generates one-cycle CPU clock-enable pulses, either single-step or free-running at a divided rate.
- Snapshots NUM_CH probe words after each step and drives one LED_W-bit slice of a selected channel to the board LEDs.
- Instantiated in the top level between board I/O and the CPU core; it replaces the fixed SW-case LED mux.

Parameters:
- DATA_W, 32, width of each probe channel; must be a multiple of LED_W.
- NUM_CH, 4, number of probe channels, 1..16.
- LED_W, 8, LED bank width.
- DEB_CYCLES, 1000000, number of consecutive stable cycles needed to accept a new button level; ≥2.
- RUN_DIV, 50000000, step-pulse period in RUN mode, in clk_100MHz cycles; ≥2.
- Derived localparams:
  - CH_W = max(1, clog2(NUM_CH)).
  - BYTE_W = max(1, clog2(DATA_W/LED_W)).

Ports:
- clk_100MHz, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- Step_BTN, in, 1, raw asynchronous push button.
- run_sw, in, 1, raw switch: 0 = STEP mode, 1 = RUN mode.
- hold_sw, in, 1, raw switch: 1 = display snapshot, 0 = display live probe.
- sel, in, CH_W+BYTE_W, {channel index, slice index}; channel in the upper bits.
- probe_bus, in, NUM_CH*DATA_W, channel c occupies bits [c*DATA_W +: DATA_W].
- cpu_clk_en, out, 1, one-cycle step pulse to the CPU.
- LED, out, LED_W, selected slice (registered).
- step_count, out, 16, number of pulses issued; wraps modulo 2^16.

Behaviour:

Reset:
- rst sampled high at an edge clears everything: synchronisers, debounce counter, debounced level (stable=0), divider counter, snapshot, cpu_clk_en, LED and step_count.
- Reset mid-debounce or mid-divide discards the partial count.
- A button already held through reset release does not produce a pulse until it is released and pressed again.

Synchronisers:
- Step_BTN, run_sw and hold_sw each pass through 2 flops before use.

Debouncer:
- At each edge where synced button ≠ stable:
  - cnt increments.
  - When cnt == DEB_CYCLES-1, stable takes the synced value and cnt clears.
- At any edge where synced button == stable, cnt clears. A glitch therefore restarts the count.
- Worked timing: button high before edge 0 → stable = 1 after edge DEB_CYCLES+1.

STEP mode (synced run_sw = 0):
- cpu_clk_en = 1 for exactly the one cycle in which stable first becomes 1 (a 0→1 transition).
- Releasing the button produces no pulse.

RUN mode (synced run_sw = 1):
- The divider counts 0..RUN_DIV-1; cpu_clk_en = 1 during the cycle in which the divider equals RUN_DIV-1, then the divider wraps to 0.
- The button is ignored, but the debouncer keeps tracking it.
- Any change of synced run_sw clears the divider. No pulse is generated in the cycle of the mode change.

Counter and snapshot:
- step_count increments on the edge that ends each cpu_clk_en cycle.
- The snapshot register captures the whole probe_bus on the edge one cycle after the cpu_clk_en cycle, i.e. post-step CPU state.

Display:
- The source is the snapshot when synced hold_sw = 1, otherwise live probe_bus.
- LED is registered on every edge with bits [slice*LED_W +: LED_W] of the chosen channel; latency is 1 cycle from sel or data change.
- LED = 0 when channel index ≥ NUM_CH or slice index ≥ DATA_W/LED_W.

Test Plan:
- Reset, debounce and single pulse. Parameters: DEB_CYCLES=4, RUN_DIV=5.
  - Hold rst 2 cycles → all outputs 0.
  - Raise Step_BTN before edge 0 and hold → cpu_clk_en high only in the cycle after edge 5; step_count = 1.
  - Release and wait 10 cycles → no further pulse.
- Glitch rejection: Step_BTN high for 3 cycles then low, repeated 5 times → no pulse; step_count stays 0.
- RUN mode: set run_sw=1 → pulses exactly every 5 cycles.
  - After 20 pulses step_count = 20.
  - Button presses meanwhile add no pulses.
  - Clear run_sw → pulses stop within 3 cycles.
- Snapshot and hold: probe channel 1 = 0x12345678 at the step, changed to 0xFFFFFFFF afterwards.
  - hold_sw=1, sel={1,2} → LED = 0x34.
  - hold_sw=0 → LED = 0xFF after sync latency + 1.
- Out-of-range select: NUM_CH=3, sel channel index 3 → LED = 0x00.
- Wrap and mid-operation reset:
  - Preload 65535 pulses (RUN mode), one more → step_count = 0.
  - Assert rst while the debouncer cnt = 2 → cnt and stable clear, and no pulse is emitted after reset release with the button still held.
